// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
//
// Single-port word RAM that sits behind a CPU data port. It has a
// combinational read path and writes on the rising edge. After reset the RAM
// is swept to zero one word per cycle. mem_ready rises once the last word has
// been cleared, and the CPU uses it as its clock enable.
//
// Accesses that are misaligned, that fall outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS), or that assert read and write
// together are faults. A fault leaves the memory untouched and raises a sticky
// err flag. err_addr latches the address of the first fault.
//
// Parameters
//   BASE_ADDR      byte address of word 0
//   DEPTH_WORDS    number of 32-bit words (power of two, 2..65536)
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous reset, active low
//   data_address     byte address from the CPU data port
//   data_read        read strobe
//   data_write       write strobe
//   data_writedata   write data
//   data_readdata    combinational read data (0 unless a valid read)
//   mem_ready        high once the clear sweep has finished
//   err              sticky access-fault flag
//   err_addr         address of the first fault since reset
//   write_count      committed writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module data_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        mem_ready,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [15:0] write_count
);

  // state    | meaning
  // ST_CLEAR | sweeping zeros into the RAM; CPU strobes ignored
  // ST_READY | normal operation until the next reset
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned     AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]     DEPTH_W32 = 32'(DEPTH_WORDS);
  localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH_WORDS - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q,       state_d;
  logic [AW-1:0] sweep_idx_q, sweep_idx_d;
  logic        mem_ready_q,   mem_ready_d;
  logic        err_q,         err_d;
  logic [31:0] err_addr_q,    err_addr_d;
  logic [15:0] write_count_q, write_count_d;

  logic [31:0]   addr_offset;
  logic [31:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          misaligned;
  logic          any_strobe;
  logic          fault;
  logic          valid_read;
  logic          valid_write;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // Address decode. The lower-bound check is done on the raw address so that
  // addresses below BASE_ADDR, which wrap to huge offsets, never alias
  // low words.
  always_comb begin
    addr_offset = data_address - BASE_ADDR;
    word_idx    = addr_offset >> 2;
    mem_idx     = word_idx[AW-1:0];
    in_range    = (data_address >= BASE_ADDR) && (word_idx < DEPTH_W32);
    misaligned  = |data_address[1:0];
    any_strobe  = data_read | data_write;
    fault       = (state_q == ST_READY) && any_strobe &&
                  (misaligned || !in_range || (data_read && data_write));
    valid_read  = (state_q == ST_READY) && data_read  && !fault;
    valid_write = (state_q == ST_READY) && data_write && !fault;
  end

  always_comb begin
    data_readdata = '0;
    if (valid_read) begin
      data_readdata = mem[mem_idx];
    end
  end

  // One write port, shared by the clear sweep and CPU writes. The sweep is
  // held off while reset is asserted so that the first zero lands on the
  // first edge after release.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = mem_idx;
    mem_wdata = data_writedata;
    if (state_q == ST_CLEAR) begin
      mem_we    = reset;
      mem_waddr = sweep_idx_q;
      mem_wdata = '0;
    end else if (valid_write) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_idx_d   = sweep_idx_q;
    mem_ready_d   = mem_ready_q;
    err_d         = err_q;
    err_addr_d    = err_addr_q;
    write_count_d = write_count_q;

    case (state_q)
      ST_CLEAR: begin
        sweep_idx_d = sweep_idx_q + AW'(1);
        // The edge that clears the last word also enters READY.
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = ST_READY;
          mem_ready_d = 1'b1;
          sweep_idx_d = '0;
        end
      end
      ST_READY: begin
        if (fault) begin
          err_d = 1'b1;
          if (!err_q) begin
            err_addr_d = data_address;
          end
        end
        if (valid_write && (write_count_q != 16'hFFFF)) begin
          write_count_d = write_count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_CLEAR;
      sweep_idx_q   <= '0;
      mem_ready_q   <= 1'b0;
      err_q         <= 1'b0;
      err_addr_q    <= '0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      mem_ready_q   <= mem_ready_d;
      err_q         <= err_d;
      err_addr_q    <= err_addr_d;
      write_count_q <= write_count_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign err         = err_q;
  assign err_addr    = err_addr_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
//
// Directed bench for data_ram_responder at its default parameters (256 words
// at 0x1000). Each test task drives its own vectors and compares against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_data_ram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_address = '0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = '0;
  logic [31:0] data_readdata;
  logic        mem_ready;
  logic        err;
  logic [31:0] err_addr;
  logic [15:0] write_count;

  int n_cmp = 0;
  int n_bad = 0;

  data_ram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .mem_ready      (mem_ready),
    .err            (err),
    .err_addr       (err_addr),
    .write_count    (write_count)
  );

  always #5 clk = ~clk;

  // One access cycle: drive after the falling edge, sample the combinational
  // read data before the rising edge, then release the strobes after it.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd_same);
    @(negedge clk);
    data_read      = rd;
    data_write     = wr;
    data_address   = addr;
    data_writedata = wd;
    #1 rd_same = data_readdata;
    @(posedge clk);
    #1;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  // Counts rising edges from reset release until mem_ready, bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!mem_ready && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic reset_and_sweep(output int cycles);
    @(negedge clk);
    reset      = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ready(cycles);
  endtask

  task automatic test_reset();
    data_read    = 1'b1;
    data_address = BASE;
    #12;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL reset_err_addr: got %h expected 00000000", err_addr); end
    n_cmp++; if (write_count !== 16'h0) begin n_bad++; $display("FAIL reset_write_count: got %h expected 0000", write_count); end
    n_cmp++; if (data_readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %h expected 00000000", data_readdata); end
    data_read = 1'b0;
  endtask

  // Release reset, poke the port during the sweep (must be ignored), check
  // the ready timing and that every word reads back zero.
  task automatic test_clear_sweep();
    int cyc;
    logic [31:0] rd;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (!mem_ready && cyc < 400) begin
      data_read  = 1'b0;
      data_write = 1'b0;
      if (cyc < 20) begin
        data_write = 1'b1; data_address = BASE; data_writedata = 32'hFFFF_FFFF;
      end else if (cyc < 40) begin
        data_read = 1'b1; data_address = BASE + 32'h1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 255) begin
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL sweep_early_ready: got %b expected 0 at cycle 255", mem_ready); end
      end
    end
    data_read  = 1'b0;
    data_write = 1'b0;
    n_cmp++; if (cyc !== 256) begin n_bad++; $display("FAIL sweep_ready_cycles: got %0d expected 256", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sweep_err: got %b expected 0", err); end
    n_cmp++; if (write_count !== 16'h0) begin n_bad++; $display("FAIL sweep_write_count: got %h expected 0000", write_count); end
    for (int i = 0; i < 256; i++) begin
      do_access(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0, rd);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sweep_zero word %0d: got %h expected 00000000", i, rd); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h1004, 32'hDEAD_BEEF, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wr_same_cycle: got %h expected 00000000", rd); end
    do_access(1'b1, 1'b0, 32'h1004, 32'h0, rd);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_readback: got %h expected deadbeef", rd); end
    n_cmp++; if (write_count !== 16'd1) begin n_bad++; $display("FAIL wr_count: got %h expected 0001", write_count); end
  endtask

  // First and last word, then two writes on consecutive cycles.
  task automatic test_back_to_back();
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h1000, 32'h1111_1111, rd);
    do_access(1'b0, 1'b1, 32'h13FC, 32'h2222_2222, rd);
    do_access(1'b0, 1'b1, 32'h1010, 32'hA0A0_0001, rd);
    do_access(1'b0, 1'b1, 32'h1014, 32'hB0B0_0002, rd);
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, rd);
    n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_first_word: got %h expected 11111111", rd); end
    do_access(1'b1, 1'b0, 32'h13FC, 32'h0, rd);
    n_cmp++; if (rd !== 32'h2222_2222) begin n_bad++; $display("FAIL b2b_last_word: got %h expected 22222222", rd); end
    do_access(1'b1, 1'b0, 32'h1010, 32'h0, rd);
    n_cmp++; if (rd !== 32'hA0A0_0001) begin n_bad++; $display("FAIL b2b_word4: got %h expected a0a00001", rd); end
    do_access(1'b1, 1'b0, 32'h1014, 32'h0, rd);
    n_cmp++; if (rd !== 32'hB0B0_0002) begin n_bad++; $display("FAIL b2b_word5: got %h expected b0b00002", rd); end
    n_cmp++; if (write_count !== 16'd5) begin n_bad++; $display("FAIL b2b_count: got %h expected 0005", write_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b expected 0", err); end
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'h1002, 32'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL fault_misaligned_rd: got %h expected 00000000", rd); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL fault_err_set: got %b expected 1", err); end
    n_cmp++; if (err_addr !== 32'h1002) begin n_bad++; $display("FAIL fault_err_addr: got %h expected 00001002", err_addr); end
    do_access(1'b0, 1'b1, 32'h1400, 32'h5555_5555, rd);
    n_cmp++; if (err_addr !== 32'h1002) begin n_bad++; $display("FAIL fault_err_addr_hold: got %h expected 00001002", err_addr); end
    n_cmp++; if (write_count !== 16'd5) begin n_bad++; $display("FAIL fault_count_1400: got %h expected 0005", write_count); end
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, rd);
    n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL fault_no_wrap: got %h expected 11111111", rd); end
    do_access(1'b1, 1'b0, 32'h1400, 32'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL fault_oor_rd: got %h expected 00000000", rd); end
    do_access(1'b0, 1'b1, 32'h0FFC, 32'h9999_9999, rd);
    n_cmp++; if (write_count !== 16'd5) begin n_bad++; $display("FAIL fault_count_below: got %h expected 0005", write_count); end
    do_access(1'b1, 1'b0, 32'h13FC, 32'h0, rd);
    n_cmp++; if (rd !== 32'h2222_2222) begin n_bad++; $display("FAIL fault_below_alias: got %h expected 22222222", rd); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL fault_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_rw_both();
    int cyc;
    logic [31:0] rd;
    reset_and_sweep(cyc);
    n_cmp++; if (cyc !== 256) begin n_bad++; $display("FAIL rw_ready_cycles: got %0d expected 256", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rw_err_cleared: got %b expected 0", err); end
    do_access(1'b1, 1'b1, 32'h1008, 32'h1234_5678, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rw_same_cycle: got %h expected 00000000", rd); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rw_err: got %b expected 1", err); end
    n_cmp++; if (err_addr !== 32'h1008) begin n_bad++; $display("FAIL rw_err_addr: got %h expected 00001008", err_addr); end
    n_cmp++; if (write_count !== 16'd0) begin n_bad++; $display("FAIL rw_count: got %h expected 0000", write_count); end
    do_access(1'b1, 1'b0, 32'h1008, 32'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rw_word_unchanged: got %h expected 00000000", rd); end
  endtask

  // Asynchronous clear from READY, then a reset pulse in the middle of the
  // sweep that must restart it from word 0.
  task automatic test_reset_mid_clear();
    int cyc;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h1004, 32'hCAFE_F00D, rd);
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL async_mem_ready: got %b expected 0", mem_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b expected 0", err); end
    n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL async_err_addr: got %h expected 00000000", err_addr); end
    n_cmp++; if (write_count !== 16'h0) begin n_bad++; $display("FAIL async_write_count: got %h expected 0000", write_count); end
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_mem_ready: got %b expected 0", mem_ready); end
    n_cmp++; if (data_readdata !== 32'h0) begin n_bad++; $display("FAIL mid_readdata: got %h expected 00000000", data_readdata); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ready(cyc);
    n_cmp++; if (cyc !== 256) begin n_bad++; $display("FAIL mid_ready_cycles: got %0d expected 256", cyc); end
    do_access(1'b1, 1'b0, 32'h1004, 32'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_mem_cleared: got %h expected 00000000", rd); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      data_write     = 1'b1;
      data_address   = BASE + 32'((i % 256) * 4);
      data_writedata = 32'(i);
    end
    @(posedge clk);
    #1 data_write = 1'b0;
    n_cmp++; if (write_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_65534: got %h expected fffe", write_count); end
    do_access(1'b0, 1'b1, 32'h1008, 32'h0000_0001, rd);
    n_cmp++; if (write_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_65535: got %h expected ffff", write_count); end
    do_access(1'b0, 1'b1, 32'h1008, 32'h0000_0002, rd);
    do_access(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5, rd);
    n_cmp++; if (write_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h expected ffff", write_count); end
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, rd);
    n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sat_commit: got %h expected a5a5a5a5", rd); end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_back_to_back();
    test_faults();
    test_rw_both();
    test_reset_mid_clear();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
